sblk_act_feeder: RTL



---
 rtl/sblk_pkg.sv | 18 +
 rtl/sblk_act_feeder_if.sv | 32 +++
 rtl/sblk_act_feeder_act_rd_pipe.sv | 56 +++++
 rtl/sblk_act_feeder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sblk_pkg.sv
// Shared definitions for the sub-block activation feeder.
// Contents: feeder FSM state encoding, default activation/address widths,
// and the packed stream-word type (two activations per word).
package sblk_pkg;

  localparam int unsigned WID_ACT_DEF   = 8;
  localparam int unsigned WID_MADDR_DEF = 12;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_REQ,
    STREAM,
    DRAIN
  } feed_state_e;

  typedef logic [2*WID_ACT_DEF-1:0] act_word_t;

endpackage

// File: rtl/sblk_act_feeder_if.sv
// Bus bundle between the activation feeder, the sub-block controller and the
// global activation memory read port.
//   act_in_req   controller -> feeder : one-cycle batch request
//   act_in_vld   feeder -> controller : stream word valid
//   act_in       feeder -> controller : stream word
//   mem_rd_en    feeder -> memory     : read enable
//   mem_rd_addr  feeder -> memory     : read address
//   mem_rd_data  memory -> feeder     : read data, fixed latency after mem_rd_en
// Modports: master = feeder side, slave = controller/memory side.
interface sblk_act_feeder_if
  import sblk_pkg::*;
#(
  parameter int unsigned WID_ACT   = WID_ACT_DEF,
  parameter int unsigned WID_MADDR = WID_MADDR_DEF
);
  logic                   act_in_req;
  logic                   act_in_vld;
  logic [2*WID_ACT-1:0]   act_in;
  logic                   mem_rd_en;
  logic [WID_MADDR-1:0]   mem_rd_addr;
  logic [2*WID_ACT-1:0]   mem_rd_data;

  modport master (
    input  act_in_req, mem_rd_data,
    output act_in_vld, act_in, mem_rd_en, mem_rd_addr
  );

  modport slave (
    output act_in_req, mem_rd_data,
    input  act_in_vld, act_in, mem_rd_en, mem_rd_addr
  );
endinterface

// File: rtl/sblk_act_feeder_act_rd_pipe.sv
// act_rd_pipe: tracks words in flight through the fixed-latency memory read
// port and registers them onto the activation stream.
// Ports:
//   clk_l, rst_n  clock, asynchronous active-low reset
//   flush         synchronous: drop everything in flight, suppress output valid
//   issue         a stream position enters this cycle (read or zero pad)
//   pad           the entering position is a zero pad (no memory data)
//   rd_data       memory read data, aligned with the oldest in-flight slot
//   out_vld       registered stream valid
//   out_word      registered stream word, holds when out_vld is low
//   empty         no positions in flight (output register excluded)
module act_rd_pipe #(
  parameter int unsigned WID_WORD = 16,
  parameter int unsigned RD_LAT   = 2
) (
  input  logic                clk_l,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                issue,
  input  logic                pad,
  input  logic [WID_WORD-1:0] rd_data,
  output logic                out_vld,
  output logic [WID_WORD-1:0] out_word,
  output logic                empty
);

  logic [RD_LAT-1:0] vld_sr;
  logic [RD_LAT-1:0] pad_sr;

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr   <= '0;
      pad_sr   <= '0;
      out_vld  <= 1'b0;
      out_word <= '0;
    end else if (flush) begin
      vld_sr  <= '0;
      pad_sr  <= '0;
      out_vld <= 1'b0;
    end else begin
      vld_sr[0] <= issue;
      pad_sr[0] <= pad;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        pad_sr[i] <= pad_sr[i-1];
      end
      out_vld <= vld_sr[RD_LAT-1];
      if (vld_sr[RD_LAT-1]) begin
        out_word <= pad_sr[RD_LAT-1] ? '0 : rd_data;
      end
    end
  end

  assign empty = ~|vld_sr;

endmodule

// File: rtl/sblk_act_feeder.sv
// sblk_act_feeder: answers each batch request from the sub-block controller by
// reading one batch of activation words from the global activation memory and
// presenting it as a contiguous valid/word stream. Counts batches per
// instruction and reports busy/done to the dispatcher.
// Ports:
//   clk_l, rst_n         clock, asynchronous active-low reset
//   cfg_en               one-cycle config strobe (aborts a running instruction)
//   cfg_base             first word address of the instruction
//   cfg_blen             words per batch
//   cfg_nbatch           batches per instruction
//   cfg_pad_from         (ACT_FEED_ZPAD_EN only) first zero-padded batch position
//   bus                  master side of sblk_act_feeder_if (request, stream, memory)
//   busy                 config loaded, instruction not finished
//   done                 one-cycle pulse when the instruction has finished
//   err_req_ovf          sticky: request arrived while one was already pending
// Optional feature macro: ACT_FEED_ZPAD_EN (zero padding of trailing positions).
module sblk_act_feeder
  import sblk_pkg::*;
#(
  parameter int unsigned N_TILE     = 4,
  parameter int unsigned WID_ACT    = WID_ACT_DEF,
  parameter int unsigned WID_MADDR  = WID_MADDR_DEF,
  parameter int unsigned WID_BLEN   = 8,
  parameter int unsigned WID_NBATCH = 6,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic                  clk_l,
  input  logic                  rst_n,
  input  logic                  cfg_en,
  input  logic [WID_MADDR-1:0]  cfg_base,
  input  logic [WID_BLEN-1:0]   cfg_blen,
  input  logic [WID_NBATCH-1:0] cfg_nbatch,
`ifdef ACT_FEED_ZPAD_EN
  input  logic [WID_BLEN-1:0]   cfg_pad_from,
`endif
  sblk_act_feeder_if.master     bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err_req_ovf
);

  if (RD_LAT < 1 || N_TILE < 1 || WID_ACT < 1) begin : g_param_check
    $error("sblk_act_feeder: RD_LAT, N_TILE and WID_ACT must be >= 1");
  end

  feed_state_e state, state_nxt;

  logic [WID_MADDR-1:0]  base;
  logic [WID_MADDR-1:0]  offset;
  logic [WID_BLEN-1:0]   blen;
  logic [WID_BLEN-1:0]   word_cnt;
  logic [WID_NBATCH-1:0] nbatch;
  logic [WID_NBATCH-1:0] batch_cnt;
  logic                  pending;

  logic cfg_zero;
  logic last_word;
  logic last_batch;
  logic pad_pos;
  logic pipe_empty;
  logic issue;
  logic flush;
  logic take_req;
  logic drain_done;

  assign cfg_zero   = (cfg_blen == '0) || (cfg_nbatch == '0);
  assign last_word  = WID_BLEN'(word_cnt + 1'b1) == blen;
  assign last_batch = WID_NBATCH'(batch_cnt + 1'b1) == nbatch;

`ifdef ACT_FEED_ZPAD_EN
  logic [WID_BLEN-1:0] pad_from;
  assign pad_pos = (word_cnt >= pad_from);
`else
  assign pad_pos = 1'b0;
`endif

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    issue         = 1'b0;
    flush         = 1'b0;
    take_req      = 1'b0;
    drain_done    = 1'b0;
    bus.mem_rd_en = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_en && !cfg_zero) state_nxt = WAIT_REQ;
      end
      WAIT_REQ: begin
        if (bus.act_in_req || pending) begin
          take_req  = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        issue         = 1'b1;
        bus.mem_rd_en = !pad_pos;
        if (last_word) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (pipe_empty) begin
          drain_done = 1'b1;
          state_nxt  = last_batch ? IDLE : WAIT_REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A config strobe outside IDLE overrides whatever the state decided: the
    // in-flight reads are flushed and the new instruction waits for a request.
    if (cfg_en && state != IDLE) begin
      flush      = 1'b1;
      take_req   = 1'b0;
      drain_done = 1'b0;
      state_nxt  = cfg_zero ? IDLE : WAIT_REQ;
    end
  end

  assign bus.mem_rd_addr = base + offset;

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      base        <= '0;
      offset      <= '0;
      blen        <= '0;
      word_cnt    <= '0;
      nbatch      <= '0;
      batch_cnt   <= '0;
      pending     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_req_ovf <= 1'b0;
`ifdef ACT_FEED_ZPAD_EN
      pad_from    <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (cfg_en) begin
        base      <= cfg_base;
        blen      <= cfg_blen;
        nbatch    <= cfg_nbatch;
`ifdef ACT_FEED_ZPAD_EN
        pad_from  <= cfg_pad_from;
`endif
        offset    <= '0;
        word_cnt  <= '0;
        batch_cnt <= '0;
        pending   <= 1'b0;
        busy      <= !cfg_zero;
        done      <= cfg_zero;
      end else begin
        if (issue) begin
          word_cnt <= last_word ? '0 : WID_BLEN'(word_cnt + 1'b1);
          if (!pad_pos) offset <= offset + 1'b1;
        end
        if (take_req) begin
          // A request arriving together with a consumed pending one re-arms it.
          pending <= pending && bus.act_in_req;
        end else if ((state == STREAM || state == DRAIN) && bus.act_in_req) begin
          if (pending) err_req_ovf <= 1'b1;
          else         pending     <= 1'b1;
        end
        if (drain_done) begin
          batch_cnt <= WID_NBATCH'(batch_cnt + 1'b1);
          if (last_batch) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            pending <= 1'b0;
          end
        end
      end
    end
  end

  act_rd_pipe #(
    .WID_WORD (2*WID_ACT),
    .RD_LAT   (RD_LAT)
  ) u_rd_pipe (
    .clk_l    (clk_l),
    .rst_n    (rst_n),
    .flush    (flush),
    .issue    (issue),
    .pad      (pad_pos),
    .rd_data  (bus.mem_rd_data),
    .out_vld  (bus.act_in_vld),
    .out_word (bus.act_in),
    .empty    (pipe_empty)
  );

endmodule
